solver_restart_ctrl: RTL
========================

Name: solver_restart_ctrl

Overview:
Multi-restart scheduler for the one-max hill-climbing solver core. On a host command it clears and launches the core repeatedly, up to MAX_RESTARTS runs. Each run is bounded by an ITER_LIMIT cycle budget. The controller keeps the best solution across all runs and returns it to the host through a valid/ready result handshake. It sits between the host/CSR layer and one solver instance, and owns that instance's start and clear.

Parameters:
N_BITS, 1024, solution width; must equal the core's N_BITS.
MAX_RESTARTS, 8, maximum core runs per command, >=1.
ITER_LIMIT, 4096, cycles allowed per run in RUN, >=2.
FIT_W, $clog2(N_BITS)+2, fitness width; matches the core's fitness port.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_start  in  1  host request; sampled only in IDLE.
cmd_abort  in  1  host abort; honoured in every non-IDLE state.
busy  out  1  high in every state except IDLE.
result_valid  out  1  result available; high only in DONE.
result_ready  in  1  host accepts the result.
result_solution  out  N_BITS  best solution over all runs.
result_fitness  out  FIT_W  fitness of result_solution.
result_runs  out  $clog2(MAX_RESTARTS)+1  number of runs executed.
result_timeouts  out  $clog2(MAX_RESTARTS)+1  number of runs ended by the iteration budget.
core_clear  out  1  one-cycle pulse; the integrator inverts it into the core's rst_n.
core_start  out  1  one-cycle start pulse to the core.
core_done  in  1  core reached optimum.
core_best_solution  in  N_BITS  core best solution.
core_best_fitness  in  FIT_W  core best fitness.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - All outputs are 0, including result_* registers and all counters.
- All outputs are registered.
- FSM states: IDLE, CLEAR, LAUNCH, RUN, COLLECT, DONE.
- IDLE:
  - When cmd_start=1, go to CLEAR.
  - On that transition: best_fit<=0, best_sol<=0, runs<=0, timeouts<=0.
- CLEAR:
  - core_clear=1 for exactly this one cycle.
  - Go to LAUNCH.
- LAUNCH:
  - core_start=1 for exactly this one cycle.
  - iter_cnt<=0.
  - Go to RUN.
- RUN:
  - iter_cnt increments every cycle.
  - core_done=1: go to COLLECT, with no timeout.
  - Otherwise, iter_cnt==ITER_LIMIT-1: go to COLLECT and increment timeouts.
  - If both happen in the same cycle, core_done wins and timeouts is not incremented.
  - Maximum time in RUN is ITER_LIMIT cycles.
- COLLECT (one cycle):
  - runs<=runs+1.
  - If core_best_fitness > best_fit (strict), capture solution and fitness. On a tie, the earlier run is kept.
  - If core_best_fitness==N_BITS or runs+1==MAX_RESTARTS: go to DONE.
  - Otherwise: go to CLEAR.
- DONE:
  - result_valid=1 and result_* stay stable.
  - Leave to IDLE in the cycle after result_valid&&result_ready. result_valid drops that cycle.
  - cmd_start is ignored in DONE.
- Abort:
  - cmd_abort=1 in any non-IDLE state: next state is IDLE, core_clear=1 for one cycle, result_valid=0.
  - result_* registers keep their last values but are not flagged valid.
  - Abort takes precedence over every other transition, including the DONE handshake.
  - Abort in IDLE has no effect.
- Timing from cmd_start to first core_start: start is sampled at edge 0, CLEAR occupies cycle 1, and core_start is high in cycle 2.
- Minimum per-restart overhead: 3 cycles (COLLECT, CLEAR, LAUNCH).
- iter_cnt width is $clog2(ITER_LIMIT)+1 and it never wraps; exit from RUN is forced at the limit.
- core_best_* are sampled only in COLLECT; their values in other states are don't-care.
- Reset mid-operation drops everything; no core_clear pulse is generated (the core shares the system reset).

Test Plan:
1. Core model asserts core_done at RUN cycle 10 with fitness=1024 -> runs=1, timeouts=0, result_fitness=1024, result_valid 1 cycle after COLLECT; core_start seen exactly once.
2. Core never done; fitness per run 500,620,620,610,...; MAX_RESTARTS=8, ITER_LIMIT=16 -> 8 runs, timeouts=8, result_fitness=620 with the run-2 solution (tie keeps the earlier run), each RUN exactly 16 cycles.
3. core_done rises on the same cycle iter_cnt==ITER_LIMIT-1 -> COLLECT with timeouts unchanged.
4. cmd_abort in RUN of run 3 -> next cycle IDLE, busy=0, core_clear pulse, result_valid never asserted; a new cmd_start then runs cleanly from runs=0.
5. DONE with result_ready held low 20 cycles, cmd_start pulsed meanwhile -> outputs stable and start ignored; ready=1 -> IDLE next cycle.
6. Assert rst asynchronously mid-RUN (between edges) -> outputs 0 immediately, state IDLE, no core_start until a new cmd_start.

Source files
------------

// File: rtl/solver_restart_ctrl.sv
// Multi-restart scheduler for the one-max solver core: clears/launches the core
// up to MAX_RESTARTS times, keeps the best solution, and hands it to the host.
//
// state   | meaning
// IDLE    | waiting for cmd_start
// CLEAR   | core_clear pulse to reset the core
// LAUNCH  | core_start pulse, iteration counter zeroed
// RUN     | core running, bounded by ITER_LIMIT cycles
// COLLECT | compare core result against best so far, count the run
// DONE    | result presented to host until accepted
module solver_restart_ctrl #(
  parameter int N_BITS       = 1024,
  parameter int MAX_RESTARTS = 8,
  parameter int ITER_LIMIT   = 4096,
  parameter int FIT_W        = $clog2(N_BITS) + 2,
  localparam int RUN_W       = $clog2(MAX_RESTARTS) + 1,
  localparam int ITER_W      = $clog2(ITER_LIMIT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic              cmd_abort,
  output logic              busy,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [N_BITS-1:0] result_solution,
  output logic [FIT_W-1:0]  result_fitness,
  output logic [RUN_W-1:0]  result_runs,
  output logic [RUN_W-1:0]  result_timeouts,
  output logic              core_clear,
  output logic              core_start,
  input  logic              core_done,
  input  logic [N_BITS-1:0] core_best_solution,
  input  logic [FIT_W-1:0]  core_best_fitness
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    LAUNCH  = 3'd2,
    RUN     = 3'd3,
    COLLECT = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t             state, state_nxt;
  logic [ITER_W-1:0]  iter_cnt;
  logic [RUN_W-1:0]   runs_inc;
  logic               abort;
  logic               iter_last;

  assign runs_inc  = result_runs + RUN_W'(1);
  assign abort     = cmd_abort && (state != IDLE);
  assign iter_last = (iter_cnt == ITER_W'(ITER_LIMIT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_start) state_nxt = CLEAR;
      CLEAR:   state_nxt = LAUNCH;
      LAUNCH:  state_nxt = RUN;
      RUN:     if (core_done || iter_last) state_nxt = COLLECT;
      COLLECT: begin
        if ((core_best_fitness == FIT_W'(N_BITS)) || (runs_inc == RUN_W'(MAX_RESTARTS)))
          state_nxt = DONE;
        else
          state_nxt = CLEAR;
      end
      DONE:    if (result_valid && result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  // Outputs are decoded from the next state so each is a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      busy            <= 1'b0;
      result_valid    <= 1'b0;
      core_clear      <= 1'b0;
      core_start      <= 1'b0;
      iter_cnt        <= '0;
      result_runs     <= '0;
      result_timeouts <= '0;
      result_fitness  <= '0;
      result_solution <= '0;
    end else begin
      state        <= state_nxt;
      busy         <= (state_nxt != IDLE);
      result_valid <= (state_nxt == DONE);
      core_clear   <= (state_nxt == CLEAR) || abort;
      core_start   <= (state_nxt == LAUNCH);
      if (!abort) begin
        case (state)
          IDLE: begin
            if (cmd_start) begin
              result_runs     <= '0;
              result_timeouts <= '0;
              result_fitness  <= '0;
              result_solution <= '0;
            end
          end
          LAUNCH: iter_cnt <= '0;
          RUN: begin
            iter_cnt <= iter_cnt + ITER_W'(1);
            // core_done wins over a simultaneous budget expiry
            if (!core_done && iter_last)
              result_timeouts <= result_timeouts + RUN_W'(1);
          end
          COLLECT: begin
            result_runs <= runs_inc;
            if (core_best_fitness > result_fitness) begin
              result_fitness  <= core_best_fitness;
              result_solution <= core_best_solution;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
